// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the UART configuration bank: field positions,
// channel FSM states, config word layout and word helper functions.
// Optional feature macro: UART_CFG_LOCK_EN (per-channel write lock via bit 0).
package uart_cfg_pkg;

  localparam int unsigned DIV_LSB   = 16;
  localparam int unsigned FSZ_LSB   = 13;
  localparam int unsigned FEN_BIT   = 12;
  localparam int unsigned RXEN_BIT  = 11;
  localparam int unsigned TXEN_BIT  = 10;
  localparam int unsigned STOP2_BIT = 9;
  localparam int unsigned PAR_LSB   = 7;
  localparam int unsigned DBITS_LSB = 4;
  localparam int unsigned RSVD_W    = 4;
`ifdef UART_CFG_LOCK_EN
  localparam int unsigned LOCK_BIT  = 0;
`endif

  localparam logic [15:0] MIN_DIVISOR   = 16'd16;
  localparam logic [2:0]  MAX_DATA_BITS = 3'd3;
  localparam logic [2:0]  MAX_FIFO_SIZE = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_APPLY
  } ch_state_e;

  typedef struct packed {
    logic [15:0] divisor;
    logic [2:0]  fifo_size;
    logic        fifo_en;
    logic        rx_en;
    logic        tx_en;
    logic        two_stop;
    logic [1:0]  parity;
    logic [2:0]  data_bits;
    logic [3:0]  rsvd;
  } uart_cfg_t;

  // Reset word: divisor for the default baud, 8N1, TX/RX/FIFO enabled.
  function automatic logic [31:0] cfg_default_word(input int unsigned clk_freq,
                                                   input int unsigned baud);
    logic [31:0] w;
    int unsigned div;
    div = clk_freq / baud - 32'd1;
    w = '0;
    w[DIV_LSB +: 16]  = div[15:0];
    w[FSZ_LSB +: 3]   = 3'b010;
    w[FEN_BIT]        = 1'b1;
    w[RXEN_BIT]       = 1'b1;
    w[TXEN_BIT]       = 1'b1;
    w[STOP2_BIT]      = 1'b0;
    w[PAR_LSB +: 2]   = 2'b00;
    w[DBITS_LSB +: 3] = 3'b011;
    return w;
  endfunction

  function automatic logic cfg_valid(input uart_cfg_t c);
    return (c.divisor >= MIN_DIVISOR) && (c.data_bits <= MAX_DATA_BITS) &&
           (c.fifo_size <= MAX_FIFO_SIZE);
  endfunction

endpackage

// File: rtl/uart_cfg_channel.sv
// One UART channel's shadow/active config pair with its commit FSM
// (IDLE -> WAIT_IDLE -> APPLY). Optional lock under UART_CFG_LOCK_EN.
module uart_cfg_channel
  import uart_cfg_pkg::*;
#(
  parameter logic [31:0] DEFAULT_WORD = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_i,
  input  logic        commit_i,
  input  logic [31:0] data_i,
  input  logic        idle_i,
  input  logic        err_clear_i,
  output logic [31:0] shadow_o,
  output logic [31:0] active_o,
  output logic        pending_o,
  output logic        apply_pulse_o,
  output logic        err_o
);

  ch_state_e   state_q, state_d;
  logic [31:0] shadow_q, shadow_d, active_q, active_d;
  logic        err_q, err_d;
  logic        busy, blocked, wr_ok, commit_ok, word_ok, err_set;
  logic [31:0] wr_word, commit_word;

  assign busy = (state_q != ST_IDLE);

`ifdef UART_CFG_LOCK_EN
  // Bit 0 survives the write mask so it can carry the lock request.
  localparam logic [31:0] WR_MASK = {{(32-RSVD_W){1'b1}}, {RSVD_W{1'b0}}} | (32'd1 << LOCK_BIT);
  logic lock_q, lock_d;

  // Lock latches when a word with the lock bit is applied; only reset clears it.
  always_comb begin
    lock_d = lock_q | ((state_q == ST_APPLY) & shadow_q[LOCK_BIT]);
  end

  // Lock register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_q <= 1'b0;
    else       lock_q <= lock_d;
  end

  assign blocked = busy | lock_q;
`else
  localparam logic [31:0] WR_MASK = {{(32-RSVD_W){1'b1}}, {RSVD_W{1'b0}}};
  assign blocked = busy;
`endif

  // A same-cycle write is validated and committed in place of the old shadow.
  assign wr_word     = data_i & WR_MASK;
  assign wr_ok       = wr_i & ~blocked;
  assign commit_word = wr_ok ? wr_word : shadow_q;
  assign word_ok     = cfg_valid(uart_cfg_t'(commit_word));
  assign commit_ok   = commit_i & ~blocked & word_ok;
  assign err_set     = ((wr_i | commit_i) & blocked) | (commit_i & ~blocked & ~word_ok);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (commit_ok) state_d = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (idle_i)    state_d = ST_APPLY;
      ST_APPLY:                    state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    pending_o     = (state_q == ST_WAIT_IDLE);
    apply_pulse_o = (state_q == ST_APPLY);
  end

  // Datapath next values; a new error outranks a same-cycle clear.
  always_comb begin
    shadow_d = wr_ok ? wr_word : shadow_q;
    active_d = (state_q == ST_APPLY) ? shadow_q : active_q;
    err_d    = err_set ? 1'b1 : (err_clear_i ? 1'b0 : err_q);
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= DEFAULT_WORD;
      active_q <= DEFAULT_WORD;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  assign shadow_o = shadow_q;
  assign active_o = active_q;
  assign err_o    = err_q;

endmodule

// File: rtl/uart_config_bank.sv
// Bank of NUM_CH UART configuration channels with shared write/commit
// bus and combinational readback. Optional macro: UART_CFG_LOCK_EN.
module uart_config_bank
  import uart_cfg_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ   = 100_000_000,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DEFAULT_BAUD = 9600,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_write,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [31:0]         cfg_data,
  input  logic                cfg_commit,
  input  logic [NUM_CH-1:0]   ch_idle,
  input  logic                rd_shadow,
  output logic [31:0]         cfg_rdata,
  output logic [NUM_CH*32-1:0] active_cfg,
  output logic [NUM_CH-1:0]   pending,
  output logic [NUM_CH-1:0]   apply_pulse,
  output logic [NUM_CH-1:0]   cfg_err,
  input  logic [NUM_CH-1:0]   err_clear
);

  localparam logic [31:0] DEFAULT_WORD = cfg_default_word(CLOCK_FREQ, DEFAULT_BAUD);

  logic [31:0] shadow_w [NUM_CH];
  logic [31:0] active_w [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic sel;
    assign sel = (32'(cfg_ch) == g);

    uart_cfg_channel #(
      .DEFAULT_WORD (DEFAULT_WORD)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .wr_i          (cfg_write & sel),
      .commit_i      (cfg_commit & sel),
      .data_i        (cfg_data),
      .idle_i        (ch_idle[g]),
      .err_clear_i   (err_clear[g]),
      .shadow_o      (shadow_w[g]),
      .active_o      (active_w[g]),
      .pending_o     (pending[g]),
      .apply_pulse_o (apply_pulse[g]),
      .err_o         (cfg_err[g])
    );

    assign active_cfg[g*32 +: 32] = active_w[g];
  end

  // Readback mux; an out-of-range channel matches nothing and reads 0.
  always_comb begin
    cfg_rdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(cfg_ch) == i) cfg_rdata = rd_shadow ? shadow_w[i] : active_w[i];
    end
  end

endmodule

// File: tb/tb_uart_config_bank.sv
module tb_uart_config_bank;

  localparam int unsigned NCH = 4;
  localparam logic [31:0] DEF = 32'h28AF_5C30;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_write, cfg_commit, rd_shadow;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_data;
  logic [3:0]  ch_idle, err_clear;
  logic [31:0] cfg_rdata;
  logic [127:0] active_cfg;
  logic [3:0]  pending, apply_pulse, cfg_err;
  logic [31:0] rdata3;
  logic [95:0] active3;
  logic [2:0]  pending3, pulse3, err3;

  uart_config_bank #(.CLOCK_FREQ(100_000_000), .NUM_CH(4), .DEFAULT_BAUD(9600)) u_dut (
    .clk(clk), .reset(reset), .cfg_write(cfg_write), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .ch_idle(ch_idle), .rd_shadow(rd_shadow), .cfg_rdata(cfg_rdata),
    .active_cfg(active_cfg), .pending(pending), .apply_pulse(apply_pulse), .cfg_err(cfg_err),
    .err_clear(err_clear)
  );

  uart_config_bank #(.CLOCK_FREQ(100_000_000), .NUM_CH(3), .DEFAULT_BAUD(9600)) u_dut3 (
    .clk(clk), .reset(reset), .cfg_write(cfg_write), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .ch_idle(ch_idle[2:0]), .rd_shadow(rd_shadow), .cfg_rdata(rdata3),
    .active_cfg(active3), .pending(pending3), .apply_pulse(pulse3), .cfg_err(err3),
    .err_clear(err_clear[2:0])
  );

  always #5 clk = ~clk;

  typedef struct { int ch; logic [31:0] word; int cyc; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc_n = 0;
  logic [31:0] chk_word [NCH];
  bit          chk_pend [NCH];

  function automatic logic [31:0] act(input int ch);
    return active_cfg[ch*32 +: 32];
  endfunction

  // Scoreboard side: pops expected applies when the DUT pulses.
  task automatic monitor();
    for (int c = 0; c < NCH; c++) begin
      if (chk_pend[c]) begin
        checks++;
        if (act(c) !== chk_word[c]) begin
          errors++;
          $display("FAIL active_after_apply ch%0d: got %h expected %h", c, act(c), chk_word[c]);
        end
        chk_pend[c] = 1'b0;
      end
      if (apply_pulse[c] === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse ch%0d cycle %0d: got pulse expected none", c, cyc_n);
        end else begin
          exp_t e = sb.pop_front();
          if (e.ch != c || e.cyc != cyc_n) begin
            errors++;
            $display("FAIL apply_pulse: got ch%0d cycle %0d expected ch%0d cycle %0d", c, cyc_n, e.ch, e.cyc);
          end
          chk_word[c] = e.word;
          chk_pend[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_pulse: got %0d outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic rd(input int ch, input bit sh, output logic [31:0] v);
    cfg_ch = ch[1:0];
    rd_shadow = sh;
    #1;
    v = cfg_rdata;
  endtask

  task automatic drive(input int ch, input bit wr, input bit cm, input logic [31:0] d);
    cfg_ch = ch[1:0]; cfg_write = wr; cfg_commit = cm; cfg_data = d;
    step();
    cfg_write = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (act(c) !== DEF) begin errors++; $display("FAIL reset_active ch%0d: got %h expected %h", c, act(c), DEF); end
    end
    checks++;
    if (pending !== 4'b0 || apply_pulse !== 4'b0 || cfg_err !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got pend=%b pulse=%b err=%b expected 0000", pending, apply_pulse, cfg_err);
    end
    rd(0, 1'b1, v);
    checks++;
    if (v !== DEF) begin errors++; $display("FAIL reset_shadow: got %h expected %h", v, DEF); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] v;
    ch_idle = '1;
    sb.push_back('{ch: 3, word: 32'h0300_0010, cyc: cyc_n + 2});
    drive(3, 1'b1, 1'b1, 32'h0300_0010);
    rd(3, 1'b1, v);
    checks++;
    if (rdata3 !== 32'h0) begin errors++; $display("FAIL oor_rdata_shadow: got %h expected 0", rdata3); end
    checks++;
    if (v !== 32'h0300_0010) begin errors++; $display("FAIL inrange_shadow ch3: got %h expected 03000010", v); end
    rd(3, 1'b0, v);
    checks++;
    if (rdata3 !== 32'h0) begin errors++; $display("FAIL oor_rdata_active: got %h expected 0", rdata3); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pending3 !== 3'b0 || pulse3 !== 3'b0 || err3 !== 3'b0) begin
        errors++;
        $display("FAIL oor_flags: got pend=%b pulse=%b err=%b expected 000", pending3, pulse3, err3);
      end
      step();
    end
    drain(1);
    checks++;
    if (active3 !== {3{DEF}}) begin errors++; $display("FAIL oor_active: got %h expected %h", active3, {3{DEF}}); end
  endtask

  task automatic test_commit();
    logic [31:0] v;
    ch_idle = '1;
    drive(1, 1'b1, 1'b0, 32'h0363_1C30);
    rd(1, 1'b1, v);
    checks++;
    if (v !== 32'h0363_1C30) begin errors++; $display("FAIL shadow_write ch1: got %h expected 03631C30", v); end
    sb.push_back('{ch: 1, word: 32'h0363_1C30, cyc: cyc_n + 2});
    drive(1, 1'b0, 1'b1, 32'h0);
    drain(4);
    drive(1, 1'b1, 1'b0, 32'h0363_1C3E);
    rd(1, 1'b1, v);
    checks++;
    if (v !== 32'h0363_1C30) begin errors++; $display("FAIL reserved_mask: got %h expected 03631C30", v); end
  endtask

  task automatic test_wait_idle();
    ch_idle = 4'b1011;
    drive(2, 1'b1, 1'b1, 32'h0145_3AB0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (pending[2] !== 1'b1 || act(2) !== DEF) begin
        errors++;
        $display("FAIL wait_idle cycle %0d: got pend=%b active=%h expected 1 %h", i, pending[2], act(2), DEF);
      end
      step();
    end
    ch_idle[2] = 1'b1;
    sb.push_back('{ch: 2, word: 32'h0145_3AB0, cyc: cyc_n + 1});
    step();
    drain(4);
  endtask

  task automatic test_invalid();
    ch_idle = '1;
    drive(0, 1'b1, 1'b1, 32'h000F_1C30);
    checks++;
    if (cfg_err[0] !== 1'b1 || pending[0] !== 1'b0) begin
      errors++; $display("FAIL div15: got err=%b pend=%b expected 1 0", cfg_err[0], pending[0]);
    end
    drain(3);
    checks++;
    if (act(0) !== DEF) begin errors++; $display("FAIL div15_active: got %h expected %h", act(0), DEF); end
    err_clear[0] = 1'b1; step(); err_clear[0] = 1'b0;
    checks++;
    if (cfg_err[0] !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", cfg_err[0]); end
    drive(0, 1'b1, 1'b1, 32'h0363_FC30);
    checks++;
    if (cfg_err[0] !== 1'b1) begin errors++; $display("FAIL fifo7: got %b expected 1", cfg_err[0]); end
    err_clear[0] = 1'b1;
    drive(0, 1'b0, 1'b1, 32'h0);
    err_clear[0] = 1'b0;
    checks++;
    if (cfg_err[0] !== 1'b1) begin errors++; $display("FAIL err_vs_clear: got %b expected 1", cfg_err[0]); end
    err_clear[0] = 1'b1; step(); err_clear[0] = 1'b0;
    sb.push_back('{ch: 0, word: 32'h0010_DC30, cyc: cyc_n + 2});
    drive(0, 1'b1, 1'b1, 32'h0010_DC30);
    drain(4);
    checks++;
    if (cfg_err[0] !== 1'b0) begin errors++; $display("FAIL boundary_valid: got err=%b expected 0", cfg_err[0]); end
  endtask

  task automatic test_busy_write();
    logic [31:0] v;
    ch_idle = 4'b0111;
    drive(3, 1'b1, 1'b1, 32'h0444_0010);
    drive(3, 1'b1, 1'b0, 32'h1234_0010);
    checks++;
    if (cfg_err[3] !== 1'b1) begin errors++; $display("FAIL busy_write_err: got %b expected 1", cfg_err[3]); end
    rd(3, 1'b1, v);
    checks++;
    if (v !== 32'h0444_0010) begin errors++; $display("FAIL busy_write_shadow: got %h expected 04440010", v); end
    err_clear[3] = 1'b1; step(); err_clear[3] = 1'b0;
    checks++;
    if (cfg_err[3] !== 1'b0 || pending[3] !== 1'b1) begin
      errors++; $display("FAIL busy_clear: got err=%b pend=%b expected 0 1", cfg_err[3], pending[3]);
    end
    drive(3, 1'b0, 1'b1, 32'h0);
    checks++;
    if (cfg_err[3] !== 1'b1) begin errors++; $display("FAIL busy_commit_err: got %b expected 1", cfg_err[3]); end
    ch_idle[3] = 1'b1;
    sb.push_back('{ch: 3, word: 32'h0444_0010, cyc: cyc_n + 1});
    step();
    drain(4);
    err_clear[3] = 1'b1; step(); err_clear[3] = 1'b0;
  endtask

  task automatic test_back_to_back();
    ch_idle = '1;
    for (int c = 0; c < NCH; c++) begin
      cfg_ch = 2'(c); cfg_write = 1'b1; cfg_commit = 1'b1;
      cfg_data = 32'h0100_0010 + (32'(c) << 16);
      sb.push_back('{ch: c, word: 32'h0100_0010 + (32'(c) << 16), cyc: cyc_n + 2});
      step();
    end
    cfg_write = 1'b0; cfg_commit = 1'b0;
    drain(5);
    checks++;
    if (cfg_err !== 4'b0) begin errors++; $display("FAIL b2b_err: got %b expected 0000", cfg_err); end
  endtask

`ifdef UART_CFG_LOCK_EN
  task automatic test_lock();
    logic [31:0] v;
    ch_idle = '1;
    sb.push_back('{ch: 0, word: 32'h0100_0011, cyc: cyc_n + 2});
    drive(0, 1'b1, 1'b1, 32'h0100_0011);
    drain(4);
    drive(0, 1'b1, 1'b0, 32'h0200_0010);
    checks++;
    if (cfg_err[0] !== 1'b1) begin errors++; $display("FAIL lock_err: got %b expected 1", cfg_err[0]); end
    rd(0, 1'b1, v);
    checks++;
    if (v !== 32'h0100_0011) begin errors++; $display("FAIL lock_shadow: got %h expected 01000011", v); end
    reset = 1'b1; step(); reset = 1'b0;
    sb.push_back('{ch: 0, word: 32'h0200_0010, cyc: cyc_n + 2});
    drive(0, 1'b1, 1'b1, 32'h0200_0010);
    drain(4);
    checks++;
    if (cfg_err[0] !== 1'b0) begin errors++; $display("FAIL lock_after_reset: got err=%b expected 0", cfg_err[0]); end
  endtask
`endif

  task automatic test_reset_mid_wait();
    logic [31:0] v;
    ch_idle = 4'b1011;
    drive(2, 1'b1, 1'b1, 32'h0200_0010);
    step();
    checks++;
    if (pending[2] !== 1'b1) begin errors++; $display("FAIL pre_reset_pending: got %b expected 1", pending[2]); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (pending[2] !== 1'b0) begin errors++; $display("FAIL async_reset_pending: got %b expected 0", pending[2]); end
    step();
    reset = 1'b0;
    rd(2, 1'b1, v);
    checks++;
    if (v !== DEF || act(2) !== DEF) begin
      errors++; $display("FAIL reset_mid_wait: got shadow=%h active=%h expected %h", v, act(2), DEF);
    end
    ch_idle = '1;
    drain(4);
  endtask

  initial begin
    reset = 1'b1; cfg_write = 1'b0; cfg_commit = 1'b0; rd_shadow = 1'b0;
    cfg_ch = '0; cfg_data = '0; ch_idle = '1; err_clear = '0;
    for (int c = 0; c < NCH; c++) begin chk_pend[c] = 1'b0; chk_word[c] = '0; end
    test_reset();
    test_out_of_range();
    test_commit();
    test_wait_idle();
    test_invalid();
    test_busy_write();
    test_back_to_back();
`ifdef UART_CFG_LOCK_EN
    test_lock();
`endif
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
